ipsum_buffer: RTL and testbench
===============================

# ipsum_buffer

Input-side partial-sum buffer that is the load-direction counterpart of the opsum drain path. It accepts 32-bit words from the GLB, two 16-bit partial sums per word, and assembles 16 words into one 32-row × 16-bit vector. It stores up to DEPTH complete vectors in a circular FIFO and presents the oldest one to the PE array/reducer with a valid/pop handshake.

## Interface
- ROW_NUM, 32: rows per vector; must be even. Words per vector WPV = ROW_NUM/2.
- DATA_W, 16: bits per row partial sum; GLB word width is 2*DATA_W.
- DEPTH, 4: number of complete vectors stored; power of two.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- clear  in  1  synchronous flush; highest priority after reset.
- glb_valid  in  1  GLB word present on glb_data.
- glb_ready  out  1  buffer accepts a word this cycle.
- glb_data  in  2*DATA_W  row 2k in [DATA_W-1:0], row 2k+1 in upper half.
- ipsum_valid  out  1  head vector available.
- ipsum_pop  in  1  consumer removes head vector.
- ipsum_out  out  ROW_NUM*DATA_W  head vector; row r at [r*DATA_W +: DATA_W].
- level  out  $clog2(DEPTH)+1  number of complete vectors stored (0..DEPTH).
- word_cnt  out  $clog2(WPV)  index of the next word within the vector being assembled.

## Operation
- Acceptance: a word is accepted on an edge where glb_valid && glb_ready.
- Staging: ROW_NUM-2 staging registers hold rows 0..ROW_NUM-3.
  - Accepting a word with word_cnt=k<WPV-1 writes rows 2k and 2k+1, then increments word_cnt.
- Commit: accepting the word with word_cnt=WPV-1 writes staging rows 0..ROW_NUM-3 plus the incoming word (rows ROW_NUM-2/ROW_NUM-1) into FIFO slot wr_ptr in that same edge.
  - wr_ptr increments, word_cnt wraps to 0.
  - Staging contents are not cleared; the next vector overwrites them.
- Back-pressure: glb_ready = !(level==DEPTH && word_cnt==WPV-1).
  - Staging may keep filling while the FIFO is full; only the committing word stalls.
  - glb_ready has no combinational path from ipsum_pop.
- Read side:
  - ipsum_valid = (level!=0).
  - ipsum_out = slot rd_ptr when valid, otherwise all zeros.
  - A pop with ipsum_valid=1 advances rd_ptr; a pop while empty is ignored.
- Simultaneous commit and pop: both pointers advance and level is unchanged.
  - A commit into a full FIFO is impossible because glb_ready=0.
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - level tracks occupancy: +1 on commit only, -1 on pop only.
- clear: on the edge, level, pointers and word_cnt go to 0 and staging registers go to 0.
  - Any concurrent word acceptance or pop in that cycle is discarded.
- reset (async, active-low): all storage, staging, pointers, level and word_cnt go to 0.
  - A partially assembled vector is lost.
- Reset values of outputs: glb_ready=1, ipsum_valid=0, ipsum_out=0, level=0, word_cnt=0.

## Timing
- Fill latency: a vector whose last word is accepted at edge N has ipsum_valid=1 and its data on ipsum_out in the cycle after edge N.
- Minimum spacing between commits is WPV (16) cycles; with continuous glb_valid the sustained input rate is 1 word/cycle.
- Pop at edge N: the next head (or zeros and ipsum_valid=0) is visible after edge N.
- glb_ready, ipsum_valid and level are functions of registered state only.
- ipsum_out is a combinational mux of registered FIFO storage indexed by rd_ptr.
- Full-stall release: a pop at edge N with level==DEPTH and word_cnt==WPV-1 raises glb_ready after edge N.
  - The stalled word is accepted at edge N+1 at the earliest.

## Test plan
- Single vector: stream 16 words, word k = {16'(2k+1+0x100), 16'(2k+0x100)}, with no pops. Required:
  - after the 16th edge, ipsum_valid=1 and level=1;
  - row r of ipsum_out = 0x100+r;
  - word_cnt=0.
- Fill to full: commit 4 distinct vectors, then offer 15 more words. Required:
  - all 15 words are accepted and word_cnt=15;
  - glb_ready=0 and level=4;
  - the 16th word stalls for 10 cycles with no state change.
- Release and ordering: from the full stall, pulse ipsum_pop once. Required:
  - glb_ready rises the next cycle and the stalled word commits;
  - level returns to 4;
  - popping 4 vectors yields vectors 2,3,4,5 in order, then ipsum_valid=0 and ipsum_out=0.
- Simultaneous commit and pop: with level=2, pop on the same edge the 16th word is accepted. Required:
  - level stays 2;
  - the head advances to the next vector;
  - pointers wrap correctly over 3 full DEPTH cycles.
- Gapped input and empty pop: drive glb_valid with random gaps and pop while empty. Required:
  - the assembled vector is identical to the gap-free case;
  - empty pops leave level=0 and pointers unchanged.
- Flush and reset mid-vector: after 7 words, assert clear. Required:
  - word_cnt=0, level=0, ipsum_valid=0.
  - Repeat with reset low for 1 cycle asynchronous to clk: all outputs take their reset values immediately.
  - The next 16 words form a clean vector with no stale rows.

Source files
------------

// File: rtl/ipsum_buffer.sv
// ipsum_buffer: input-side partial-sum buffer.
// This block takes 32-bit GLB words. Each word carries two row partial sums.
// It assembles WPV words into one ROW_NUM-row vector.
// It holds up to DEPTH finished vectors in a circular FIFO.
// The oldest vector is presented on the read side.
// Ports:
//   clk, reset (async, active-low), clear (sync flush)
//   glb_valid/glb_ready/glb_data   : word input handshake
//   ipsum_valid/ipsum_pop/ipsum_out : head-vector read handshake
//   level    : number of complete vectors stored
//   word_cnt : index of the next word in the vector being assembled
module ipsum_buffer #(
  parameter int unsigned ROW_NUM = 32,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          glb_valid,
  output logic                          glb_ready,
  input  logic [2*DATA_W-1:0]           glb_data,
  output logic                          ipsum_valid,
  input  logic                          ipsum_pop,
  output logic [ROW_NUM*DATA_W-1:0]     ipsum_out,
  output logic [$clog2(DEPTH):0]        level,
  output logic [$clog2(ROW_NUM/2)-1:0]  word_cnt
);

  localparam int unsigned WPV    = ROW_NUM / 2;
  localparam int unsigned WC_W   = $clog2(WPV);
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
  localparam int unsigned WORD_W = 2 * DATA_W;
  localparam int unsigned VEC_W  = ROW_NUM * DATA_W;
  localparam int unsigned STG_N  = WPV - 1;

  logic [WORD_W-1:0] stage_q [STG_N];
  logic [VEC_W-1:0]  mem_q   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [VEC_W-1:0]  commit_vec;
  logic              last_word, accept, commit, pop_ok;

  // Handshake qualifiers.
  // Every term here comes from registered state or from an input.
  // This keeps glb_ready free of any path from ipsum_pop.
  assign last_word   = (word_cnt == WC_W'(WPV - 1));
  assign glb_ready   = !((level == LVL_W'(DEPTH)) && last_word);
  assign ipsum_valid = (level != '0);
  assign accept      = glb_valid && glb_ready;
  assign commit      = accept && last_word;
  assign pop_ok      = ipsum_pop && ipsum_valid;
  assign ipsum_out   = ipsum_valid ? mem_q[rd_ptr] : '0;

  // Full vector that is written on commit.
  // It is the staged words plus the incoming word, which fills the last two rows.
  always_comb begin
    commit_vec = '0;
    for (int unsigned i = 0; i < STG_N; i++) begin
      commit_vec[i*WORD_W +: WORD_W] = stage_q[i];
    end
    commit_vec[STG_N*WORD_W +: WORD_W] = glb_data;
  end

  // Staging registers and the assembly word counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt <= '0;
      for (int unsigned i = 0; i < STG_N; i++) stage_q[i] <= '0;
    end else if (clear) begin
      word_cnt <= '0;
      for (int unsigned i = 0; i < STG_N; i++) stage_q[i] <= '0;
    end else if (accept) begin
      word_cnt <= last_word ? '0 : word_cnt + WC_W'(1);
      for (int unsigned i = 0; i < STG_N; i++) begin
        if (word_cnt == WC_W'(i)) stage_q[i] <= glb_data;
      end
    end
  end

  // FIFO storage.
  // The slot contents survive a clear, because level and the pointers hide stale data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!clear && commit) begin
      mem_q[wr_ptr] <= commit_vec;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (commit) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({commit, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_ipsum_buffer.sv
// Self-checking bench for ipsum_buffer.
// A queue-based reference model tracks the stored vectors and the assembly position.
module tb_ipsum_buffer;

  localparam int unsigned ROW_NUM = 32;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned WPV     = ROW_NUM / 2;
  localparam int unsigned VEC_W   = ROW_NUM * DATA_W;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  clear = 1'b0;
  logic                  glb_valid = 1'b0;
  logic                  glb_ready;
  logic [2*DATA_W-1:0]   glb_data = '0;
  logic                  ipsum_valid;
  logic                  ipsum_pop = 1'b0;
  logic [VEC_W-1:0]      ipsum_out;
  logic [2:0]            level;
  logic [3:0]            word_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: the stored vectors, the partial vector and the next word index.
  logic [VEC_W-1:0] q[$];
  logic [VEC_W-1:0] part = '0;
  int               wc = 0;

  ipsum_buffer #(.ROW_NUM(ROW_NUM), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .glb_valid(glb_valid), .glb_ready(glb_ready), .glb_data(glb_data),
    .ipsum_valid(ipsum_valid), .ipsum_pop(ipsum_pop), .ipsum_out(ipsum_out),
    .level(level), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Enter at a negedge.
  // Check all outputs against the model, then drive one cycle of inputs.
  // The model then advances past the posedge.
  task automatic step(input logic v, input logic [31:0] d, input logic p, input logic c);
    logic exp_ready, acc, pop_ok;
    exp_ready = !(q.size() == DEPTH && wc == WPV - 1);
    check("glb_ready", VEC_W'(glb_ready), VEC_W'(exp_ready));
    check("ipsum_valid", VEC_W'(ipsum_valid), VEC_W'(q.size() != 0));
    check("level", VEC_W'(level), VEC_W'(q.size()));
    check("word_cnt", VEC_W'(word_cnt), VEC_W'(wc));
    check("ipsum_out", ipsum_out, (q.size() != 0) ? q[0] : '0);
    glb_valid = v; glb_data = d; ipsum_pop = p; clear = c;
    @(posedge clk);
    if (c) begin
      q.delete();
      wc = 0;
    end else begin
      pop_ok = p && (q.size() != 0);
      acc    = v && exp_ready;
      if (pop_ok) void'(q.pop_front());
      if (acc) begin
        part[wc*32 +: 32] = d;
        if (wc == WPV - 1) begin
          q.push_back(part);
          wc = 0;
        end else begin
          wc++;
        end
      end
    end
    @(negedge clk);
    glb_valid = 1'b0; ipsum_pop = 1'b0; clear = 1'b0;
  endtask

  task automatic send_vec(input logic pop_last);
    for (int k = 0; k < WPV; k++) step(1'b1, $urandom, pop_last && (k == WPV - 1), 1'b0);
  endtask

  task automatic reset_checks();
    check("rst_ready", VEC_W'(glb_ready), VEC_W'(1));
    check("rst_valid", VEC_W'(ipsum_valid), '0);
    check("rst_out", ipsum_out, '0);
    check("rst_level", VEC_W'(level), '0);
    check("rst_word_cnt", VEC_W'(word_cnt), '0);
  endtask

  // Pull reset low partway through a cycle, check immediately, and hold it across a posedge.
  task automatic async_reset();
    #3 reset = 1'b0;
    #1 reset_checks();
    q.delete();
    wc = 0;
    #9 reset = 1'b1;
    @(negedge clk);
  endtask

  logic [VEC_W-1:0] ref_vec;
  logic [31:0]      words [WPV];
  int               sent;
  int               budget;

  initial begin
    #1 reset_checks();
    #11 reset = 1'b1;
    @(negedge clk);

    // Single vector: build the expected rows independently, as 0x100+r.
    for (int k = 0; k < WPV; k++)
      step(1'b1, {16'(2*k + 1 + 'h100), 16'(2*k + 'h100)}, 1'b0, 1'b0);
    for (int r = 0; r < ROW_NUM; r++) ref_vec[r*DATA_W +: DATA_W] = 16'('h100 + r);
    check("single_out", ipsum_out, ref_vec);
    check("single_level", VEC_W'(level), VEC_W'(1));
    check("single_valid", VEC_W'(ipsum_valid), VEC_W'(1));
    check("single_word_cnt", VEC_W'(word_cnt), '0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Fill to full, then stage 15 more words and stall the committing word.
    for (int v = 0; v < DEPTH; v++) send_vec(1'b0);
    for (int k = 0; k < WPV - 1; k++) step(1'b1, $urandom, 1'b0, 1'b0);
    check("full_word_cnt", VEC_W'(word_cnt), VEC_W'(15));
    check("full_ready", VEC_W'(glb_ready), '0);
    check("full_level", VEC_W'(level), VEC_W'(4));
    glb_data = $urandom;
    for (int i = 0; i < 10; i++) step(1'b1, glb_data, 1'b0, 1'b0);
    // Release: a single pop, with the stalled word still offered.
    step(1'b1, glb_data, 1'b1, 1'b0);
    check("release_ready", VEC_W'(glb_ready), VEC_W'(1));
    step(1'b1, glb_data, 1'b0, 1'b0);
    check("release_level", VEC_W'(level), VEC_W'(4));
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("drain_out", ipsum_out, '0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Simultaneous commit and pop at level 2, across three pointer wraps.
    send_vec(1'b0);
    send_vec(1'b0);
    for (int v = 0; v < 3 * DEPTH; v++) begin
      send_vec(1'b1);
      check("simul_level", VEC_W'(level), VEC_W'(2));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Gapped input with pops while empty, then the same words sent without gaps.
    for (int k = 0; k < WPV; k++) words[k] = $urandom;
    sent = 0;
    budget = 0;
    while (sent < WPV && budget < 2000) begin
      budget++;
      if ($urandom_range(0, 2) == 0) begin
        step(1'b1, words[sent], 1'b0, 1'b0);
        sent++;
      end else begin
        step(1'b0, $urandom, (q.size() == 0) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
      end
    end
    check("gap_done", VEC_W'(sent), VEC_W'(WPV));
    for (int r = 0; r < WPV; r++) ref_vec[r*32 +: 32] = words[r];
    check("gap_out", ipsum_out, ref_vec);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("empty_pop_level", VEC_W'(level), '0);
    for (int k = 0; k < WPV; k++) step(1'b1, words[k], 1'b0, 1'b0);
    check("nogap_out", ipsum_out, ref_vec);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush mid-vector, with a word and a pop offered in the same cycle.
    send_vec(1'b0);
    for (int k = 0; k < 7; k++) step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b1, 1'b1);
    check("clear_word_cnt", VEC_W'(word_cnt), '0);
    check("clear_level", VEC_W'(level), '0);
    check("clear_valid", VEC_W'(ipsum_valid), '0);
    send_vec(1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-vector, then a clean vector.
    for (int k = 0; k < 7; k++) step(1'b1, $urandom, 1'b0, 1'b0);
    async_reset();
    send_vec(1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
